// File: rtl/exec_if.sv
// -----------------------------------------------------------------------------
// exec_if
// Issue and data-memory bus of the execute unit.
//   Issue bus : in_valid/in_ready handshake plus decoded fields
//               (in_uop, in_cond, in_setf, in_imm_sel, in_imm, in_rd/rs1/rs2).
//   Memory bus: mem_req/mem_we/mem_addr/mem_wdata out of the unit,
//               mem_ack/mem_rdata back into it.
// Modports:
//   slave  - the execute unit
//   master - its environment (decode stage plus data memory)
// Parameters: XLEN datapath width, RW register-select width.
// -----------------------------------------------------------------------------
interface exec_if #(
  parameter int XLEN = 32,
  parameter int RW   = 4
);
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      in_uop;
  logic [3:0]      in_cond;
  logic            in_setf;
  logic            in_imm_sel;
  logic [XLEN-1:0] in_imm;
  logic [RW-1:0]   in_rd;
  logic [RW-1:0]   in_rs1;
  logic [RW-1:0]   in_rs2;

  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_ack;
  logic [XLEN-1:0] mem_rdata;

  modport slave (
    input  in_valid, in_uop, in_cond, in_setf, in_imm_sel, in_imm,
           in_rd, in_rs1, in_rs2,
    output in_ready,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport master (
    output in_valid, in_uop, in_cond, in_setf, in_imm_sel, in_imm,
           in_rd, in_rs1, in_rs2,
    input  in_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/exec_unit.sv
// -----------------------------------------------------------------------------
// exec_unit
// Single-issue execute stage: register file, NZCV flags, ALU, branch condition
// evaluation and a handshaked multi-cycle data-memory port.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          exec_if.slave (issue handshake + memory bus)
//   br_valid     one-cycle taken-branch pulse, br_offset the offset to apply
//   illegal      one-cycle pulse after an illegal uop is accepted
//   flags_out    current {N,Z,C,V}
//   dbg_sel      combinational register read select, dbg_data its value
// Configuration macro: EXEC_MUL_EN - iterative shift-add MUL (uop 13).
//   Without it uop 13 is treated as illegal.
// -----------------------------------------------------------------------------
module exec_unit #(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 16,
  localparam int RW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  exec_if.slave           bus,
  output logic            br_valid,
  output logic [XLEN-1:0] br_offset,
  output logic            illegal,
  output logic [3:0]      flags_out,
  input  logic [RW-1:0]   dbg_sel,
  output logic [XLEN-1:0] dbg_data
);

  localparam int SW  = $clog2(XLEN);
  localparam int MSB = XLEN - 1;

  typedef enum logic [4:0] {
    UOP_NOP = 5'd0,  UOP_MOV = 5'd1,  UOP_ADD = 5'd2,  UOP_SUB = 5'd3,
    UOP_AND = 5'd4,  UOP_ORR = 5'd5,  UOP_EOR = 5'd6,  UOP_CMP = 5'd7,
    UOP_LSL = 5'd8,  UOP_LSR = 5'd9,  UOP_LDR = 5'd10, UOP_STR = 5'd11,
    UOP_B   = 5'd12, UOP_MUL = 5'd13
  } uop_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MEM   = 2'd1,
`ifdef EXEC_MUL_EN
    S_MUL   = 2'd3,
`endif
    S_FLUSH = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [XLEN-1:0] r_regs [NREGS];
  logic [3:0]      r_flags;            // {N,Z,C,V}

  logic [XLEN-1:0] r_mem_addr;
  logic [XLEN-1:0] r_mem_wdata;
  logic            r_mem_we;
  logic [RW-1:0]   r_mem_rd;
  logic            r_br_valid;
  logic [XLEN-1:0] r_br_offset;
  logic            r_illegal;

  logic            w_accept;
  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_op2;
  logic [SW-1:0]   w_shamt;
  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_diff;
  logic [XLEN:0]   w_shl;
  logic [XLEN:0]   w_shr;
  logic [XLEN-1:0] w_alu_res;
  logic            w_alu_wr;
  logic            w_alu_fl_en;
  logic            w_alu_c;
  logic            w_alu_v;
  logic            w_is_mem;
  logic            w_is_branch;
  logic            w_is_illegal;
  logic            w_cond_ok;
  logic            w_rf_we;
  logic [RW-1:0]   w_rf_idx;
  logic [XLEN-1:0] w_rf_data;
  logic            w_fl_we;
  logic [3:0]      w_fl_data;

`ifdef EXEC_MUL_EN
  logic            w_is_mul;
  logic            w_mul_last;
  logic [XLEN-1:0] w_mul_acc_nxt;
  logic [XLEN-1:0] r_mul_a;
  logic [XLEN-1:0] r_mul_b;
  logic [XLEN-1:0] r_mul_acc;
  logic [SW-1:0]   r_mul_cnt;
  logic [RW-1:0]   r_mul_rd;
  logic            r_mul_setf;
`endif

  // ARM condition codes against the current flags.
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0:    return z;
      4'd1:    return !z;
      4'd2:    return cy;
      4'd3:    return !cy;
      4'd4:    return n;
      4'd5:    return !n;
      4'd6:    return v;
      4'd7:    return !v;
      4'd8:    return cy && !z;
      4'd9:    return !cy || z;
      4'd10:   return n == v;
      4'd11:   return n != v;
      4'd12:   return !z && (n == v);
      4'd13:   return z || (n != v);
      4'd14:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  assign bus.in_ready  = (r_state == S_IDLE);
  assign w_accept      = bus.in_valid && bus.in_ready;
  // Memory request is a pure decode of the state register, so an async reset
  // drops it in the same cycle.
  assign bus.mem_req   = (r_state == S_MEM);
  assign bus.mem_we    = bus.mem_req && r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign br_valid      = r_br_valid;
  assign br_offset     = r_br_offset;
  assign illegal       = r_illegal;
  assign flags_out     = r_flags;
  assign dbg_data      = r_regs[dbg_sel];

  assign w_rs1_val = r_regs[bus.in_rs1];
  assign w_op2     = bus.in_imm_sel ? bus.in_imm : r_regs[bus.in_rs2];
  assign w_shamt   = w_op2[SW-1:0];
  assign w_sum     = {1'b0, w_rs1_val} + {1'b0, w_op2};
  assign w_diff    = {1'b0, w_rs1_val} + {1'b0, ~w_op2} + (XLEN+1)'(1);
  // Extra bit on the outside of each shift captures the last bit shifted out.
  assign w_shl     = {1'b0, w_rs1_val} << w_shamt;
  assign w_shr     = {w_rs1_val, 1'b0} >> w_shamt;
  assign w_cond_ok = cond_pass(bus.in_cond, r_flags);

  // NOTE: every signal driven in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_alu_res    = '0;
    w_alu_wr     = 1'b0;
    w_alu_fl_en  = 1'b0;
    w_alu_c      = r_flags[1];
    w_alu_v      = r_flags[0];
    w_is_mem     = 1'b0;
    w_is_branch  = 1'b0;
    w_is_illegal = 1'b0;
`ifdef EXEC_MUL_EN
    w_is_mul     = 1'b0;
`endif
    case (bus.in_uop)
      UOP_NOP: ;
      UOP_MOV: begin
        w_alu_res = w_op2;  w_alu_wr = 1'b1;  w_alu_fl_en = bus.in_setf;
      end
      UOP_ADD: begin
        w_alu_res   = w_sum[MSB:0];  w_alu_wr = 1'b1;  w_alu_fl_en = bus.in_setf;
        w_alu_c     = w_sum[XLEN];
        w_alu_v     = (w_rs1_val[MSB] == w_op2[MSB]) && (w_sum[MSB] != w_rs1_val[MSB]);
      end
      UOP_SUB, UOP_CMP: begin
        w_alu_res   = w_diff[MSB:0];
        w_alu_wr    = (bus.in_uop == UOP_SUB);
        w_alu_fl_en = bus.in_setf || (bus.in_uop == UOP_CMP);
        w_alu_c     = w_diff[XLEN];
        w_alu_v     = (w_rs1_val[MSB] != w_op2[MSB]) && (w_diff[MSB] != w_rs1_val[MSB]);
      end
      UOP_AND: begin
        w_alu_res = w_rs1_val & w_op2;  w_alu_wr = 1'b1;  w_alu_fl_en = bus.in_setf;
      end
      UOP_ORR: begin
        w_alu_res = w_rs1_val | w_op2;  w_alu_wr = 1'b1;  w_alu_fl_en = bus.in_setf;
      end
      UOP_EOR: begin
        w_alu_res = w_rs1_val ^ w_op2;  w_alu_wr = 1'b1;  w_alu_fl_en = bus.in_setf;
      end
      UOP_LSL: begin
        w_alu_res = w_shl[MSB:0];  w_alu_wr = 1'b1;  w_alu_fl_en = bus.in_setf;
        if (w_shamt != '0) w_alu_c = w_shl[XLEN];
      end
      UOP_LSR: begin
        w_alu_res = w_shr[XLEN:1];  w_alu_wr = 1'b1;  w_alu_fl_en = bus.in_setf;
        if (w_shamt != '0) w_alu_c = w_shr[0];
      end
      UOP_LDR, UOP_STR: w_is_mem = 1'b1;
      UOP_B:            w_is_branch = 1'b1;
`ifdef EXEC_MUL_EN
      UOP_MUL:          w_is_mul = 1'b1;
`endif
      default:          w_is_illegal = 1'b1;
    endcase
  end

`ifdef EXEC_MUL_EN
  assign w_mul_last    = (r_state == S_MUL) && (r_mul_cnt == SW'(XLEN - 1));
  assign w_mul_acc_nxt = r_mul_acc + (r_mul_b[0] ? r_mul_a : '0);
`endif

  // Single register-file write port and flag update; sources are exclusive
  // because issue only happens in IDLE.
  always_comb begin
    w_rf_we   = 1'b0;
    w_rf_idx  = bus.in_rd;
    w_rf_data = w_alu_res;
    w_fl_we   = 1'b0;
    w_fl_data = {w_alu_res[MSB], (w_alu_res == '0), w_alu_c, w_alu_v};
    if (w_accept) begin
      w_rf_we = w_alu_wr;
      w_fl_we = w_alu_fl_en;
    end else if ((r_state == S_MEM) && bus.mem_ack && !r_mem_we) begin
      w_rf_we   = 1'b1;
      w_rf_idx  = r_mem_rd;
      w_rf_data = bus.mem_rdata;
    end
`ifdef EXEC_MUL_EN
    else if (w_mul_last) begin
      w_rf_we   = 1'b1;
      w_rf_idx  = r_mul_rd;
      w_rf_data = w_mul_acc_nxt;
      w_fl_we   = r_mul_setf;
      w_fl_data = {w_mul_acc_nxt[MSB], (w_mul_acc_nxt == '0), r_flags[1:0]};
    end
`endif
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_is_mem)                      w_state_nxt = S_MEM;
          else if (w_is_branch && w_cond_ok) w_state_nxt = S_FLUSH;
`ifdef EXEC_MUL_EN
          else if (w_is_mul)                 w_state_nxt = S_MUL;
`endif
        end
      end
      S_MEM:   if (bus.mem_ack) w_state_nxt = S_IDLE;
`ifdef EXEC_MUL_EN
      S_MUL:   if (w_mul_last) w_state_nxt = S_IDLE;
`endif
      S_FLUSH: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: the register file is reset because software may rely on every
  // architectural register reading zero after reset; this rules out a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_flags <= '0;
    end else begin
      if (w_rf_we) r_regs[w_rf_idx] <= w_rf_data;
      if (w_fl_we) r_flags <= w_fl_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_mem_rd    <= '0;
      r_br_valid  <= 1'b0;
      r_br_offset <= '0;
      r_illegal   <= 1'b0;
    end else begin
      r_br_valid <= w_accept && w_is_branch && w_cond_ok;
      r_illegal  <= w_accept && w_is_illegal;
      if (w_accept && w_is_branch && w_cond_ok) r_br_offset <= bus.in_imm;
      // Address and data are captured once at issue and held for the whole
      // request.
      if (w_accept && w_is_mem) begin
        r_mem_addr  <= w_rs1_val + bus.in_imm;
        r_mem_wdata <= r_regs[bus.in_rs2];
        r_mem_we    <= (bus.in_uop == UOP_STR);
        r_mem_rd    <= bus.in_rd;
      end
    end
  end

`ifdef EXEC_MUL_EN
  // One shift-add step per cycle: multiplicand moves left, multiplier right.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mul_a    <= '0;
      r_mul_b    <= '0;
      r_mul_acc  <= '0;
      r_mul_cnt  <= '0;
      r_mul_rd   <= '0;
      r_mul_setf <= 1'b0;
    end else if (w_accept && w_is_mul) begin
      r_mul_a    <= w_rs1_val;
      r_mul_b    <= w_op2;
      r_mul_acc  <= '0;
      r_mul_cnt  <= '0;
      r_mul_rd   <= bus.in_rd;
      r_mul_setf <= bus.in_setf;
    end else if (r_state == S_MUL) begin
      r_mul_acc <= w_mul_acc_nxt;
      r_mul_a   <= r_mul_a << 1;
      r_mul_b   <= r_mul_b >> 1;
      r_mul_cnt <= r_mul_cnt + SW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_exec_unit.sv
// -----------------------------------------------------------------------------
// tb_exec_unit
// Directed bench for exec_unit (XLEN=32, NREGS=16): ALU ops and flags,
// branches, memory handshake, shifts, illegal uop, MUL (or its absence) and
// reset during a memory wait. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_exec_unit;
  localparam int XLEN = 32;
  localparam int RW   = 4;

  localparam logic [4:0] NOP = 5'd0,  MOV = 5'd1,  ADD = 5'd2,  SUB = 5'd3,
                         AND = 5'd4,  ORR = 5'd5,  EOR = 5'd6,  CMP = 5'd7,
                         LSL = 5'd8,  LSR = 5'd9,  LDR = 5'd10, STR = 5'd11,
                         BR  = 5'd12, MUL = 5'd13;
  localparam logic [3:0] EQ = 4'd0, NE = 4'd1, AL = 4'd14;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            br_valid;
  logic [XLEN-1:0] br_offset;
  logic            illegal;
  logic [3:0]      flags_out;
  logic [RW-1:0]   dbg_sel = '0;
  logic [XLEN-1:0] dbg_data;

  int total = 0;
  int bad   = 0;
  int cnt;

  exec_if #(.XLEN(XLEN), .RW(RW)) bus ();

  exec_unit #(.XLEN(XLEN), .NREGS(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .br_valid  (br_valid),
    .br_offset (br_offset),
    .illegal   (illegal),
    .flags_out (flags_out),
    .dbg_sel   (dbg_sel),
    .dbg_data  (dbg_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reg(input string tag, input int idx, input logic [31:0] exp);
    dbg_sel = RW'(idx);
    #1;
    check(tag, dbg_data, exp);
  endtask

  // Present one instruction, hold it across one rising edge, return 1 time
  // unit after that edge.
  task automatic issue(input logic [4:0] uop, input logic [3:0] cond, input logic setf,
                       input logic imm_sel, input logic [31:0] imm,
                       input int rd, input int rs1, input int rs2);
    @(negedge clk);
    bus.in_uop     = uop;
    bus.in_cond    = cond;
    bus.in_setf    = setf;
    bus.in_imm_sel = imm_sel;
    bus.in_imm     = imm;
    bus.in_rd      = RW'(rd);
    bus.in_rs1     = RW'(rs1);
    bus.in_rs2     = RW'(rs2);
    bus.in_valid   = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_uop   = NOP;
  endtask

  initial begin
    bus.in_valid = 1'b0;  bus.in_uop = NOP;  bus.in_cond = AL;  bus.in_setf = 1'b0;
    bus.in_imm_sel = 1'b0;  bus.in_imm = '0;  bus.in_rd = '0;  bus.in_rs1 = '0;
    bus.in_rs2 = '0;  bus.mem_ack = 1'b0;  bus.mem_rdata = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst in_ready", 32'(bus.in_ready), 32'd1);
    check("rst br_valid", 32'(br_valid), 32'd0);
    check("rst br_offset", br_offset, 32'd0);
    check("rst mem_req", 32'(bus.mem_req), 32'd0);
    check("rst mem_we", 32'(bus.mem_we), 32'd0);
    check("rst mem_addr", bus.mem_addr, 32'd0);
    check("rst mem_wdata", bus.mem_wdata, 32'd0);
    check("rst illegal", 32'(illegal), 32'd0);
    check("rst flags", 32'(flags_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // MOV / ADD with carry-out to zero
    issue(MOV, AL, 1'b0, 1'b1, 32'd5, 1, 0, 0);
    check("mov in_ready", 32'(bus.in_ready), 32'd1);
    issue(ADD, AL, 1'b1, 1'b1, 32'hFFFF_FFFB, 2, 1, 0);
    check("add in_ready", 32'(bus.in_ready), 32'd1);
    check("add flags NZCV", 32'(flags_out), 32'b0110);
    check_reg("add r2", 2, 32'd0);
    check_reg("mov r1", 1, 32'd5);

    // CMP with borrow, then equal
    issue(CMP, AL, 1'b0, 1'b1, 32'd6, 0, 1, 0);
    check("cmp lt flags", 32'(flags_out), 32'b1000);
    issue(CMP, AL, 1'b0, 1'b1, 32'd5, 0, 1, 0);
    check("cmp eq flags", 32'(flags_out), 32'b0110);
    check_reg("cmp no write r0", 0, 32'd0);

    // Taken branch: one-cycle pulse, one FLUSH cycle
    issue(BR, EQ, 1'b0, 1'b1, 32'h40, 0, 0, 0);
    check("beq br_valid", 32'(br_valid), 32'd1);
    check("beq br_offset", br_offset, 32'h40);
    check("beq in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("beq br_valid drop", 32'(br_valid), 32'd0);
    check("beq in_ready back", 32'(bus.in_ready), 32'd1);
    issue(BR, NE, 1'b0, 1'b1, 32'h80, 0, 0, 0);
    check("bne br_valid", 32'(br_valid), 32'd0);
    check("bne in_ready", 32'(bus.in_ready), 32'd1);

    // STR r1 -> [r0+0x10], ack in the third request cycle
    issue(STR, AL, 1'b0, 1'b0, 32'h10, 0, 0, 1);
    check("str mem_addr", bus.mem_addr, 32'h10);
    check("str mem_wdata", bus.mem_wdata, 32'd5);
    check("str mem_we", 32'(bus.mem_we), 32'd1);
    check("str in_ready", 32'(bus.in_ready), 32'd0);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (bus.mem_req && bus.mem_addr == 32'h10) cnt++;
      @(negedge clk);
      bus.mem_ack = (i == 2);
      @(posedge clk);
      #1;
    end
    bus.mem_ack = 1'b0;
    check("str req cycles", 32'(cnt), 32'd3);
    check("str req drop", 32'(bus.mem_req), 32'd0);
    check("str in_ready done", 32'(bus.in_ready), 32'd1);

    // LDR r3 with ack in the first request cycle
    issue(LDR, AL, 1'b0, 1'b0, 32'h20, 3, 0, 0);
    check("ldr mem_req", 32'(bus.mem_req), 32'd1);
    check("ldr mem_we", 32'(bus.mem_we), 32'd0);
    check("ldr in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    bus.mem_ack = 1'b0;
    check("ldr in_ready done", 32'(bus.in_ready), 32'd1);
    check_reg("ldr r3", 3, 32'hDEAD_BEEF);

    // Stray ack while idle is ignored
    @(negedge clk);
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'h1234_5678;
    @(posedge clk);
    #1;
    bus.mem_ack = 1'b0;
    check("stray ack mem_req", 32'(bus.mem_req), 32'd0);
    check_reg("stray ack r3", 3, 32'hDEAD_BEEF);

    // Shifts
    issue(MOV, AL, 1'b0, 1'b1, 32'd3, 1, 0, 0);
    issue(LSL, AL, 1'b1, 1'b1, 32'd31, 4, 1, 0);
    check("lsl flags", 32'(flags_out), 32'b1010);
    check_reg("lsl r4", 4, 32'h8000_0000);
    issue(LSR, AL, 1'b1, 1'b1, 32'd0, 6, 4, 0);
    check("lsr0 flags C kept", 32'(flags_out), 32'b1010);
    check_reg("lsr0 r6", 6, 32'h8000_0000);
    issue(LSR, AL, 1'b1, 1'b1, 32'd4, 7, 4, 0);
    check("lsr4 flags", 32'(flags_out), 32'b0000);
    check_reg("lsr4 r7", 7, 32'h0800_0000);

    // Logic ops, register operand, subtraction and signed overflow
    issue(EOR, AL, 1'b0, 1'b1, 32'd5, 8, 1, 0);
    issue(ORR, AL, 1'b0, 1'b1, 32'd4, 9, 1, 0);
    issue(AND, AL, 1'b0, 1'b0, 32'd0, 10, 8, 9);
    check_reg("eor r8", 8, 32'd6);
    check_reg("orr r9", 9, 32'd7);
    check_reg("and r10", 10, 32'd6);
    issue(SUB, AL, 1'b1, 1'b1, 32'd4, 11, 1, 0);
    check("sub flags", 32'(flags_out), 32'b1000);
    check_reg("sub r11", 11, 32'hFFFF_FFFF);
    issue(MOV, AL, 1'b0, 1'b1, 32'h7FFF_FFFF, 12, 0, 0);
    issue(ADD, AL, 1'b1, 1'b1, 32'd1, 12, 12, 0);
    check("add ovf flags", 32'(flags_out), 32'b1001);
    check_reg("add ovf r12", 12, 32'h8000_0000);

    // Illegal uop: pulse only, no state change
    issue(5'd20, AL, 1'b1, 1'b1, 32'd0, 12, 0, 0);
    check("ill pulse", 32'(illegal), 32'd1);
    check("ill in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    check("ill pulse end", 32'(illegal), 32'd0);
    check("ill flags", 32'(flags_out), 32'b1001);
    check_reg("ill r12", 12, 32'h8000_0000);

    // MUL 7 x 6
    issue(MOV, AL, 1'b0, 1'b1, 32'd7, 13, 0, 0);
    issue(MUL, AL, 1'b0, 1'b1, 32'd6, 5, 13, 0);
`ifdef EXEC_MUL_EN
    cnt = 0;
    while (!bus.in_ready && cnt < 100) begin
      cnt++;
      @(posedge clk);
      #1;
    end
    check("mul busy cycles", 32'(cnt), 32'd32);
    check_reg("mul r5", 5, 32'd42);
`else
    check("mul illegal", 32'(illegal), 32'd1);
    check_reg("mul r5", 5, 32'd0);
`endif

    // Reset during a memory wait
    issue(LDR, AL, 1'b0, 1'b0, 32'h30, 14, 0, 0);
    check("rstmem req before", 32'(bus.mem_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmem req drop", 32'(bus.mem_req), 32'd0);
    check("rstmem flags", 32'(flags_out), 32'd0);
    check_reg("rstmem r1", 1, 32'd0);
    check_reg("rstmem r3", 3, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rstmem in_ready", 32'(bus.in_ready), 32'd1);
    check_reg("rstmem r14", 14, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/exec_unit.md
# exec_unit

Parametrised single-issue execute unit that replaces the fixed 32-bit, 16-register, single-cycle execute stage. Sits between decode and the data memory. Contains the register file, the NZCV flags register, the ALU, condition evaluation for branches, and a handshaked multi-cycle memory port. A valid/ready input handshake lets decode stall while loads, stores and (optionally) multiplies are in flight.

## Interface
Parameters:
- XLEN, 32, datapath and register width (≥8, power of two)
- NREGS, 16, architectural register count (power of two); RW = log2(NREGS)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  unit accepts instruction this cycle
- in_uop  in  5  0 NOP, 1 MOV, 2 ADD, 3 SUB, 4 AND, 5 ORR, 6 EOR, 7 CMP, 8 LSL, 9 LSR, 10 LDR, 11 STR, 12 B, 13 MUL, 14–31 illegal
- in_cond  in  4  ARM condition (EQ..LE, 14 = AL, 15 = never), used by B only
- in_setf  in  1  ALU ops update flags
- in_imm_sel  in  1  op2 = in_imm instead of rs2
- in_imm  in  XLEN  immediate / branch offset
- in_rd, in_rs1, in_rs2  in  RW  destination, lhs, rhs/store-data selects
- br_valid  out  1  one-cycle taken-branch pulse
- br_offset  out  XLEN  offset to apply to fetch PC
- mem_req, mem_we  out  1  memory request, write enable
- mem_addr, mem_wdata  out  XLEN  address, store data
- mem_ack  in  1  request completed
- mem_rdata  in  XLEN  load data, valid with mem_ack
- illegal  out  1  one-cycle pulse on illegal uop
- flags_out  out  4  current {N,Z,C,V}
- dbg_sel  in  RW / dbg_data  out  XLEN  combinational register read port

## Operation
- States: IDLE, MEM, MUL, FLUSH. in_ready = (state == IDLE). Accept = in_valid & in_ready.
- op2 = in_imm_sel ? in_imm : R[rs2]. All arithmetic is modulo 2^XLEN.
- MOV/ADD/SUB/AND/ORR/EOR/LSL/LSR: R[rd] written at accept edge. CMP: computes rs1 − op2 and always sets flags, no write.
- Flags when in_setf (or CMP): N = msb, Z = result == 0. ADD/SUB/CMP also set C (carry; no-borrow for SUB) and V (signed overflow). LSL/LSR set C = last bit shifted out, unchanged when the shift amount is 0. Shift amount = op2[log2(XLEN)-1:0]. Logical ops leave C,V unchanged.
- LDR/STR: mem_addr = R[rs1] + in_imm. mem_wdata = R[rs2]. → MEM. mem_req is held high with stable address/data until mem_ack. LDR writes R[rd] = mem_rdata on the ack edge. → IDLE.
- B: condition evaluated against flags at accept. If true → FLUSH, and br_valid/br_offset = in_imm are registered for exactly one cycle. FLUSH lasts one cycle with in_ready low; decode discards its in-flight instruction on br_valid. Not taken: behaves as NOP.
- NOP: no effect. Illegal uop: no state change, `illegal` pulses the following cycle.
- rd write to any register index is permitted; there is no hardwired zero.

## Timing
- Reset (asynchronous): all registers 0, flags 0, state IDLE. Outputs: in_ready 1, br_valid 0, br_offset 0, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, illegal 0.
- ALU ops: 1 cycle, back-to-back issue. A following instruction reads the new value, since the write lands on the accept edge.
- Memory: mem_req rises the cycle after accept. Minimum latency is 2 cycles, accept → next accept, with mem_ack asserted in the first req cycle. mem_ack outside MEM is ignored.
- Taken branch: accept at cycle t, br_valid at t+1, in_ready low at t+1, in_ready high at t+2.
- Reset asserted mid-MEM/MUL: operation is abandoned, mem_req drops immediately, and there is no write.

## Configuration
- EXEC_MUL_EN defined: MUL runs an iterative shift-add in state MUL for XLEN cycles, then writes the low XLEN bits of R[rs1]×op2 to rd. in_setf updates N,Z only. in_ready is low for XLEN cycles after accept.
- Undefined: uop 13 is illegal (no write, `illegal` pulse), and the MUL state and logic are absent.

## Test plan
- Reset then MOV r1,#5; ADD r2,r1,#0xFFFFFFFB with setf → dbg r2 = 0, flags Z=1, C=1, N=0, V=0. in_ready stays 1 throughout.
- CMP r1,#5 with r1=5, then B EQ offset 0x40 → br_valid high exactly 1 cycle with br_offset = 0x40, in_ready low that cycle. B NE afterwards → no br_valid.
- STR r1 → [r0+0x10], ack after 3 cycles → mem_req held 3 cycles, addr 0x10, wdata 5, we=1. Then LDR r3 with rdata 0xDEADBEEF → r3 = 0xDEADBEEF, in_ready low until the ack edge.
- LSL r4,r1,#31 with r1=3 and setf → r4 = 0x80000000, C=1, N=1. LSR by 0 → C unchanged.
- uop 20 → illegal pulses 1 cycle, registers and flags unchanged. With EXEC_MUL_EN, MUL 7×6 → r5 = 42 after 32 busy cycles; without it → illegal pulse.
- rst_n low during MEM wait → mem_req 0 in the same cycle, all registers 0, in_ready 1 after release.
